mole_round_ctrl: RTL
====================

# mole_round_ctrl

Round controller for the whack-a-mole game, sitting directly downstream of `unique_selector`. It requests one unique hole index at a time and lights that mole for a fixed window. It scores a hit or a miss from the player's buttons and continues until every hole has appeared once. It drives the selector's request input and consumes its `selected_number`, `done` and `all_selected` outputs.

## Interface
- `N_BITS`, 3, hole index width; 2^N_BITS holes, must match the selector's `n`
- `UP_TICKS`, 20000, mole-visible window in clk cycles (2 s at 10 kHz)
- `GAP_TICKS`, 5000, dark gap after each mole in clk cycles
- `SCORE_W`, 4, width of the hit and miss counters

- `clk`  in  1  system clock (10 kHz)
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a round
- `btn`  in  2^N_BITS  debounced, synchronised hole buttons, level-high when pressed
- `sel_done`  in  1  selector `done`
- `sel_number`  in  N_BITS  selector `selected_number`
- `sel_all`  in  1  selector `all_selected`
- `sel_req`  out  1  one-cycle request pulse to the selector
- `sel_clr`  out  1  one-cycle active-high pulse; ORed into the selector reset
- `mole_led`  out  2^N_BITS  one-hot lit mole, all zero when no mole is up
- `hits`  out  SCORE_W  hit count, saturating
- `misses`  out  SCORE_W  miss count, saturating
- `busy`  out  1  high in every state except IDLE and FINISH
- `round_done`  out  1  level-high in FINISH

## Operation
- Reset values: state IDLE; `sel_req`, `sel_clr`, `mole_led`, `hits`, `misses`, `busy`, `round_done` all 0; edge registers and counters all 0.
- FSM states:
  - **IDLE**: on `start`, go to CLEAR.
  - **CLEAR**: assert `sel_clr`, zero `hits`, `misses` and `mole_cnt`, then go to REQ.
  - **REQ**: assert `sel_req`, then go to WAIT_SEL.
  - **WAIT_SEL**: on a rising edge of `sel_done` (current value 1, registered previous value 0), latch `sel_number` into `idx`, go to UP and clear the tick counter.
  - **UP**: `mole_led` = one-hot(`idx`). A rising edge on `btn[idx]` increments `hits`; then go to GAP. If the tick counter reaches UP_TICKS-1 with no hit, increment `misses`; then go to GAP.
  - **GAP**: `mole_led` = 0. After GAP_TICKS cycles, increment `mole_cnt`. If `sel_all`=1 or `mole_cnt` reaches 2^N_BITS, go to FINISH; otherwise go to REQ.
  - **FINISH**: `round_done`=1, `mole_led`=0. On `start`, go to CLEAR; scores hold until CLEAR.
- Button edges are detected per bit against a registered copy of `btn`, which is updated every cycle in every state.
- Only edges count. A button held from before UP is ignored until it is released and pressed again.
- Counters:
  - `hits` and `misses` saturate at 2^SCORE_W-1.
  - `mole_cnt` is N_BITS+1 bits wide.
  - The tick counter width is the clog2 of max(UP_TICKS, GAP_TICKS).
- Boundary cases:
  - `start` in any state other than IDLE or FINISH is ignored.
  - A hit edge in the same cycle as the UP timeout counts as a hit, not a miss.
  - A correct and a wrong button edge in the same cycle count as a hit only.
  - `sel_done` already high on entry to WAIT_SEL is not an edge; the controller waits for a fresh rising edge.
  - Reset asserted mid-round returns the block to IDLE immediately with all outputs 0.

## Timing
- `start` sampled at edge k:
  - `sel_clr` high during cycle k+1
  - `sel_req` high during cycle k+2
  - WAIT_SEL from cycle k+3
- `mole_led` becomes valid one cycle after the cycle in which the `sel_done` rising edge is sampled.
- A mole stays up for exactly UP_TICKS cycles on a miss. On a hit it goes dark in the cycle after the hit edge is sampled.
- GAP lasts exactly GAP_TICKS cycles. The next `sel_req` is asserted in the following cycle.
- `sel_req` and `sel_clr` are always exactly one cycle wide and never asserted together.

## Configuration
- `MOLE_PENALTY_EN` defined: in UP, a rising edge on any `btn[j]` with j≠`idx` increments `misses` (saturating); the mole stays up and the window is not restarted. Multiple wrong edges in one cycle count as one miss.
- Not defined: wrong-button edges are ignored; `misses` changes only on timeouts.

## Test plan
Bench parameters: N_BITS=3, UP_TICKS=8, GAP_TICKS=2, SCORE_W=4, driven by a real `lfsr_prng` and `unique_selector`.

- Reset, then `start` with no button presses -> 8 distinct one-hot `mole_led` patterns, each 8 cycles wide; `misses`=8, `hits`=0, `round_done`=1, `sel_all`=1.
- Bench presses `btn[idx]` 3 cycles into every UP -> `hits`=8, `misses`=0; each mole is dark in the cycle after the press.
- `btn[idx]` edge in the same cycle as the 8th tick -> scored as a hit, `misses` unchanged.
- `MOLE_PENALTY_EN` with a wrong-button press then a correct press in one UP -> `misses`=1, `hits`=1. Same stimulus without the macro -> `misses`=0, `hits`=1.
- `rst` pulled low during the 3rd UP -> `mole_led`=0, `hits`/`misses`=0, `busy`=0 within the reset window; a new `start` produces `sel_clr` then `sel_req`.
- `start` pulse during WAIT_SEL and again during FINISH -> first ignored; second produces `sel_clr` at +1 and clears the scores.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller driving a unique_selector
// Define MOLE_PENALTY_EN to score wrong-button presses during a lit mole as misses.
module mole_round_ctrl #(
    parameter int N_BITS    = 3,
    parameter int UP_TICKS  = 20000,
    parameter int GAP_TICKS = 5000,
    parameter int SCORE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_BITS-1:0] btn,
    input  logic                 sel_done,
    input  logic [N_BITS-1:0]    sel_number,
    input  logic                 sel_all,
    output logic                 sel_req,
    output logic                 sel_clr,
    output logic [2**N_BITS-1:0] mole_led,
    output logic [SCORE_W-1:0]   hits,
    output logic [SCORE_W-1:0]   misses,
    output logic                 busy,
    output logic                 round_done
);

    localparam int HOLES     = 2**N_BITS;
    localparam int MAX_TICKS = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TICK_W-1:0]  UP_LAST    = TICK_W'(UP_TICKS - 1);
    localparam logic [TICK_W-1:0]  GAP_LAST   = TICK_W'(GAP_TICKS - 1);
    localparam logic [N_BITS:0]    MOLE_TOTAL = (N_BITS + 1)'(HOLES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
`ifdef MOLE_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        REQ      = 3'd2,
        WAIT_SEL = 3'd3,
        UP       = 3'd4,
        GAP      = 3'd5,
        FINISH   = 3'd6
    } state_t;

    state_t state, state_next;

    logic [HOLES-1:0]  btn_q;
    logic              sel_done_q;
    logic [N_BITS-1:0] idx;
    logic [TICK_W-1:0] tick;
    logic [N_BITS:0]   mole_cnt;

    logic [HOLES-1:0]  btn_rise;
    logic [HOLES-1:0]  mole_mask;
    logic [N_BITS:0]   mole_cnt_inc;
    logic              sel_rise;
    logic              hit;
    logic              wrong;
    logic              timeout;
    logic              gap_end;
    logic              last_mole;
    logic              miss_evt;

    always_comb begin
        btn_rise     = btn & ~btn_q;
        mole_mask    = HOLES'(1) << idx;
        sel_rise     = sel_done & ~sel_done_q;
        hit          = |(btn_rise & mole_mask);
        wrong        = |(btn_rise & ~mole_mask);
        timeout      = (tick == UP_LAST);
        gap_end      = (tick == GAP_LAST);
        mole_cnt_inc = mole_cnt + 1'b1;
        last_mole    = sel_all || (mole_cnt_inc == MOLE_TOTAL);
        // A correct edge always wins over a timeout or a wrong press in the same cycle.
        miss_evt     = !hit && (timeout || (PENALTY && wrong));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = CLEAR;
            CLEAR:    state_next = REQ;
            REQ:      state_next = WAIT_SEL;
            WAIT_SEL: if (sel_rise) state_next = UP;
            UP:       if (hit || timeout) state_next = GAP;
            GAP:      if (gap_end) state_next = last_mole ? FINISH : REQ;
            FINISH:   if (start) state_next = CLEAR;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q      <= '0;
            sel_done_q <= 1'b0;
            idx        <= '0;
            tick       <= '0;
            mole_cnt   <= '0;
            hits       <= '0;
            misses     <= '0;
        end else begin
            btn_q      <= btn;
            sel_done_q <= sel_done;
            case (state)
                CLEAR: begin
                    hits     <= '0;
                    misses   <= '0;
                    mole_cnt <= '0;
                end
                WAIT_SEL: begin
                    if (sel_rise) begin
                        idx  <= sel_number;
                        tick <= '0;
                    end
                end
                UP: begin
                    if (hit && hits != SCORE_MAX)        hits   <= hits + 1'b1;
                    if (miss_evt && misses != SCORE_MAX) misses <= misses + 1'b1;
                    tick <= (hit || timeout) ? '0 : tick + 1'b1;
                end
                GAP: begin
                    if (gap_end) mole_cnt <= mole_cnt_inc;
                    tick <= gap_end ? '0 : tick + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_clr    = (state == CLEAR);
        sel_req    = (state == REQ);
        mole_led   = (state == UP) ? mole_mask : '0;
        busy       = (state != IDLE) && (state != FINISH);
        round_done = (state == FINISH);
    end

endmodule
